// File: rtl/bram_arbiter_pkg.sv
// Shared definitions for the two-client BRAM arbiter: default widths,
// operation encoding and client indices.
package bram_arbiter_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 16;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_e;

    localparam logic CL_A = 1'b0;
    localparam logic CL_B = 1'b1;

endpackage

// File: rtl/bram_arbiter_bram.sv
// Simple dual-port block RAM: one synchronous write port, one synchronous
// read port, read-before-write when both hit the same address on one edge.
module bram
    import bram_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/bram_arbiter.sv
// Two-client arbiter in front of one shared BRAM: dual-issues a write and a
// read from different clients, round-robins same-type conflicts.
module bram_arbiter
    import bram_arbiter_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int INIT_WAIT = 64
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    output logic              o_ready,
    input  logic              i_a_req,
    input  logic              i_a_we,
    input  logic [ADDR_W-1:0] i_a_addr,
    input  logic [DATA_W-1:0] i_a_wdata,
    output logic              o_a_ack,
    output logic [DATA_W-1:0] o_a_rdata,
    input  logic              i_b_req,
    input  logic              i_b_we,
    input  logic [ADDR_W-1:0] i_b_addr,
    input  logic [DATA_W-1:0] i_b_wdata,
    output logic              o_b_ack,
    output logic [DATA_W-1:0] o_b_rdata
);

    localparam int CNT_W = (INIT_WAIT > 1) ? $clog2(INIT_WAIT) : 1;

    logic [CNT_W-1:0]  init_cnt;
    logic              ready_p0;
    logic              ptr;
    logic              ptr_nxt;
    logic              elig_a;
    logic              elig_b;
    logic              grant_a;
    logic              grant_b;
    op_e               a_op;
    op_e               b_op;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] bram_rdata;
    logic              a_vld_p1;
    logic              b_vld_p1;
    logic              a_rd_p1;
    logic              b_rd_p1;
    logic [DATA_W-1:0] a_rdata_p2;
    logic [DATA_W-1:0] b_rdata_p2;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            init_cnt <= '0;
            ready_p0 <= 1'b0;
        end else if (!ready_p0) begin
            if (init_cnt == CNT_W'(INIT_WAIT - 1)) begin
                ready_p0 <= 1'b1;
            end else begin
                init_cnt <= init_cnt + 1'b1;
            end
        end
    end

    assign a_op = op_e'(i_a_we);
    assign b_op = op_e'(i_b_we);

    // Issue stage: a client in its ack cycle is not eligible, which paces
    // each client to one op every two cycles.
    assign elig_a = i_a_req && ready_p0 && !a_vld_p1;
    assign elig_b = i_b_req && ready_p0 && !b_vld_p1;

    always_comb begin
        grant_a = elig_a;
        grant_b = elig_b;
        ptr_nxt = ptr;
        if (elig_a && elig_b && (a_op == b_op)) begin
            if (ptr == CL_A) begin
                grant_b = 1'b0;
                ptr_nxt = CL_B;
            end else begin
                grant_a = 1'b0;
                ptr_nxt = CL_A;
            end
        end
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = i_b_addr;
        wr_data = i_b_wdata;
        rd_en   = 1'b0;
        rd_addr = i_b_addr;
        if (grant_a && a_op == OP_WR) begin
            wr_en   = 1'b1;
            wr_addr = i_a_addr;
            wr_data = i_a_wdata;
        end else if (grant_b && b_op == OP_WR) begin
            wr_en   = 1'b1;
        end
        if (grant_a && a_op == OP_RD) begin
            rd_en   = 1'b1;
            rd_addr = i_a_addr;
        end else if (grant_b && b_op == OP_RD) begin
            rd_en   = 1'b1;
        end
    end

    bram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_bram (
        .clk   (i_clk),
        .we    (wr_en),
        .waddr (wr_addr),
        .wdata (wr_data),
        .re    (rd_en),
        .raddr (rd_addr),
        .rdata (bram_rdata)
    );

    // Ack stage: acks and read flags follow the issue edge by one cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr      <= CL_A;
            a_vld_p1 <= 1'b0;
            b_vld_p1 <= 1'b0;
            a_rd_p1  <= 1'b0;
            b_rd_p1  <= 1'b0;
        end else begin
            ptr      <= ptr_nxt;
            a_vld_p1 <= grant_a;
            b_vld_p1 <= grant_b;
            a_rd_p1  <= grant_a && (a_op == OP_RD);
            b_rd_p1  <= grant_b && (b_op == OP_RD);
        end
    end

    // Hold stage: keep the last read result until that client's next read ack.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            a_rdata_p2 <= '0;
            b_rdata_p2 <= '0;
        end else begin
            if (a_rd_p1) begin
                a_rdata_p2 <= bram_rdata;
            end
            if (b_rd_p1) begin
                b_rdata_p2 <= bram_rdata;
            end
        end
    end

    assign o_ready   = ready_p0;
    assign o_a_ack   = a_vld_p1;
    assign o_b_ack   = b_vld_p1;
    assign o_a_rdata = a_rd_p1 ? bram_rdata : a_rdata_p2;
    assign o_b_rdata = b_rd_p1 ? bram_rdata : b_rdata_p2;

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter: startup wait, single-client ops, dual
// issue, same-op conflicts, sustained contention and mid-operation reset.
module tb_bram_arbiter;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        o_ready;
    logic        i_a_req;
    logic        i_a_we;
    logic [7:0]  i_a_addr;
    logic [15:0] i_a_wdata;
    logic        o_a_ack;
    logic [15:0] o_a_rdata;
    logic        i_b_req;
    logic        i_b_we;
    logic [7:0]  i_b_addr;
    logic [15:0] i_b_wdata;
    logic        o_b_ack;
    logic [15:0] o_b_rdata;

    int total = 0;
    int bad   = 0;

    always #5 i_clk = ~i_clk;

    bram_arbiter #(
        .ADDR_W    (8),
        .DATA_W    (16),
        .INIT_WAIT (64)
    ) dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .o_ready   (o_ready),
        .i_a_req   (i_a_req),
        .i_a_we    (i_a_we),
        .i_a_addr  (i_a_addr),
        .i_a_wdata (i_a_wdata),
        .o_a_ack   (o_a_ack),
        .o_a_rdata (o_a_rdata),
        .i_b_req   (i_b_req),
        .i_b_we    (i_b_we),
        .i_b_addr  (i_b_addr),
        .i_b_wdata (i_b_wdata),
        .o_b_ack   (o_b_ack),
        .o_b_rdata (o_b_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_a(input logic req, input logic we, input logic [7:0] addr, input logic [15:0] wd);
        i_a_req   = req;
        i_a_we    = we;
        i_a_addr  = addr;
        i_a_wdata = wd;
    endtask

    task automatic set_b(input logic req, input logic we, input logic [7:0] addr, input logic [15:0] wd);
        i_b_req   = req;
        i_b_we    = we;
        i_b_addr  = addr;
        i_b_wdata = wd;
    endtask

    task automatic reset_release();
        i_rst_n = 1'b0;
        repeat (2) tick();
        i_rst_n = 1'b1;
    endtask

    initial begin
        logic seen;
        i_rst_n = 1'b0;
        set_a(1'b0, 1'b0, 8'h00, 16'h0000);
        set_b(1'b0, 1'b0, 8'h00, 16'h0000);
        tick();
        chk("rst_ready", o_ready, 0);
        chk("rst_a_ack", o_a_ack, 0);
        chk("rst_b_ack", o_b_ack, 0);
        chk("rst_a_rdata", o_a_rdata, 0);
        chk("rst_b_rdata", o_b_rdata, 0);

        // A read of 0x10 presented from the first cycle after reset.
        set_a(1'b1, 1'b0, 8'h10, 16'h0000);
        reset_release();
        seen = 1'b0;
        for (int i = 0; i < 63; i++) begin
            tick();
            seen = seen | o_a_ack | o_b_ack;
        end
        chk("no_ack_init", seen, 0);
        chk("ready_63", o_ready, 0);
        tick();
        chk("ready_64", o_ready, 1);
        chk("ack_not_yet", o_a_ack, 0);
        tick();
        chk("first_read_ack", o_a_ack, 1);

        // Req kept high through the ack cycle to present a write.
        set_a(1'b1, 1'b1, 8'hFF, 16'hBE11);
        tick();
        chk("ack_cycle_ignored", o_a_ack, 0);
        tick();
        chk("wr_ff_ack", o_a_ack, 1);
        set_a(1'b1, 1'b0, 8'hFF, 16'h0000);
        tick();
        chk("wr_ff_ack_drop", o_a_ack, 0);
        tick();
        chk("rd_ff_ack", o_a_ack, 1);
        chk("rd_ff_data", o_a_rdata, 16'hBE11);
        set_a(1'b0, 1'b0, 8'h00, 16'h0000);
        tick();
        chk("rd_ff_ack_drop", o_a_ack, 0);
        chk("rd_ff_hold", o_a_rdata, 16'hBE11);

        // Dual issue: A writes 0x95 while B reads it, read sees old data.
        set_b(1'b1, 1'b1, 8'h95, 16'h0000);
        tick();
        chk("b_clear95_ack", o_b_ack, 1);
        set_b(1'b0, 1'b0, 8'h00, 16'h0000);
        tick();
        set_a(1'b1, 1'b1, 8'h95, 16'hC0DE);
        set_b(1'b1, 1'b0, 8'h95, 16'h0000);
        tick();
        chk("dual_a_ack", o_a_ack, 1);
        chk("dual_b_ack", o_b_ack, 1);
        chk("dual_b_old", o_b_rdata, 16'h0000);
        set_a(1'b0, 1'b0, 8'h00, 16'h0000);
        tick();
        chk("dual_b_ack_drop", o_b_ack, 0);
        tick();
        chk("b_reread_ack", o_b_ack, 1);
        chk("b_reread_new", o_b_rdata, 16'hC0DE);
        set_b(1'b0, 1'b0, 8'h00, 16'h0000);
        tick();

        // Both write 0x01 from reset: A first, then B.
        set_a(1'b1, 1'b1, 8'h01, 16'h1111);
        set_b(1'b1, 1'b1, 8'h01, 16'h2222);
        reset_release();
        repeat (64) tick();
        chk("ww_ready", o_ready, 1);
        tick();
        chk("ww_a_first", o_a_ack, 1);
        chk("ww_b_wait", o_b_ack, 0);
        set_a(1'b0, 1'b0, 8'h00, 16'h0000);
        tick();
        chk("ww_a_drop", o_a_ack, 0);
        chk("ww_b_second", o_b_ack, 1);
        set_b(1'b0, 1'b0, 8'h00, 16'h0000);
        set_a(1'b1, 1'b0, 8'h01, 16'h0000);
        tick();
        chk("ww_rd_ack", o_a_ack, 1);
        chk("ww_rd_data", o_a_rdata, 16'h2222);
        set_a(1'b0, 1'b0, 8'h00, 16'h0000);
        tick();

        // Sustained read contention from reset: grants alternate A, B, A, B.
        set_a(1'b1, 1'b0, 8'h01, 16'h0000);
        set_b(1'b1, 1'b0, 8'h95, 16'h0000);
        reset_release();
        repeat (64) tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("rr_a_ack%0d", i), o_a_ack, (i % 2 == 0) ? 1 : 0);
            chk($sformatf("rr_b_ack%0d", i), o_b_ack, (i % 2 == 1) ? 1 : 0);
            if (i % 2 == 0) chk($sformatf("rr_a_data%0d", i), o_a_rdata, 16'h2222);
            else            chk($sformatf("rr_b_data%0d", i), o_b_rdata, 16'hC0DE);
        end
        set_a(1'b0, 1'b0, 8'h00, 16'h0000);
        set_b(1'b0, 1'b0, 8'h00, 16'h0000);
        repeat (2) tick();

        // Reset pulsed while B's read is about to issue and ack.
        set_b(1'b1, 1'b0, 8'h95, 16'h0000);
        #3;
        i_rst_n = 1'b0;
        set_b(1'b0, 1'b0, 8'h00, 16'h0000);
        #1;
        chk("mid_rst_ready", o_ready, 0);
        chk("mid_rst_b_ack", o_b_ack, 0);
        chk("mid_rst_b_rdata", o_b_rdata, 0);
        chk("mid_rst_a_rdata", o_a_rdata, 0);
        #1;
        i_rst_n = 1'b1;
        tick();
        chk("mid_rst_no_ack", o_b_ack, 0);
        repeat (62) tick();
        chk("rewait_63", o_ready, 0);
        tick();
        chk("rewait_64", o_ready, 1);
        set_a(1'b1, 1'b0, 8'h01, 16'h0000);
        tick();
        chk("kept_ack", o_a_ack, 1);
        chk("kept_data", o_a_rdata, 16'h2222);
        set_a(1'b0, 1'b0, 8'h00, 16'h0000);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
